// File: rtl/vme_cmd_arbiter_if.sv
// rtl/vme_cmd_arbiter_if.sv - requester and vme_master signal bundle for vme_cmd_arbiter
//
// Purpose: carries every port of vme_cmd_arbiter except clk and rst.
// Modports:
//   slave  - the arbiter itself: samples requests and vme_master completion,
//            drives acks, responses, the vme_master command and status.
//   master - the environment: the requesters together with vme_master.
// Signals:
//   req_vld   [NREQ]     request pending, held until the matching req_ack
//   req_wr    [NREQ]     1 = write, 0 = read
//   req_addr  [NREQ*23]  VME address [23:1], requester i at [23i+22:23i]
//   req_wdata [NREQ*16]  write data, requester i at [16i+15:16i]
//   req_ack   [NREQ]     one-cycle completion pulse to the granted requester
//   rsp_data  [16]       read data, non-zero only while req_ack is non-zero
//   rsp_err              timeout flag, valid only while req_ack is non-zero
//   vme_cmd              one-cycle start pulse to vme_master
//   vme_wr / vme_rd      strobe levels to vme_master, held through WAIT
//   vme_addr  [23]       latched address
//   vme_wr_data [16]     latched write data
//   vme_cmd_rd           completion pulse from vme_master
//   vme_rd_data [16]     read data, valid with vme_cmd_rd
//   busy                 arbiter is not idle
//   tmo_count [8]        saturating timeout count
//   spurious             sticky: completion seen with no command outstanding
interface vme_cmd_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]    req_vld;
  logic [NREQ-1:0]    req_wr;
  logic [NREQ*23-1:0] req_addr;
  logic [NREQ*16-1:0] req_wdata;
  logic [NREQ-1:0]    req_ack;
  logic [15:0]        rsp_data;
  logic               rsp_err;
  logic               vme_cmd;
  logic               vme_wr;
  logic               vme_rd;
  logic [22:0]        vme_addr;
  logic [15:0]        vme_wr_data;
  logic               vme_cmd_rd;
  logic [15:0]        vme_rd_data;
  logic               busy;
  logic [7:0]         tmo_count;
  logic               spurious;

  modport slave (
    input  req_vld, req_wr, req_addr, req_wdata, vme_cmd_rd, vme_rd_data,
    output req_ack, rsp_data, rsp_err, vme_cmd, vme_wr, vme_rd, vme_addr,
           vme_wr_data, busy, tmo_count, spurious
  );

  modport master (
    output req_vld, req_wr, req_addr, req_wdata, vme_cmd_rd, vme_rd_data,
    input  req_ack, rsp_data, rsp_err, vme_cmd, vme_wr, vme_rd, vme_addr,
           vme_wr_data, busy, tmo_count, spurious
  );
endinterface

// File: rtl/vme_cmd_arbiter.sv
// rtl/vme_cmd_arbiter.sv - round-robin sharing of the vme_master command port
//
// Purpose: picks one of NREQ requesters round-robin, latches its command,
// issues a one-cycle vme_cmd, then waits for vme_cmd_rd or a timeout and
// returns read data / error status with a one-cycle req_ack.
// Ports:
//   clk  - system clock, all logic on the rising edge
//   rst  - synchronous active-high reset; abandons any transaction in flight
//   bus  - vme_cmd_arbiter_if slave modport (requests, responses,
//          vme_master command/completion, busy/tmo_count/spurious status)
// Parameters:
//   NREQ    - number of requesters, 2..4
//   TMO_W   - timeout timer width
//   TIMEOUT - WAIT-state cycles before the transaction is aborted
module vme_cmd_arbiter #(
  parameter int NREQ    = 2,
  parameter int TMO_W   = 8,
  parameter int TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             rst,
  vme_cmd_arbiter_if.slave bus
);

  localparam int               GW       = $clog2(NREQ);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           state;
  logic [GW-1:0]    grant;
  logic [GW-1:0]    last_grant;
  logic [TMO_W-1:0] timer;

  logic             vme_cmd_q;
  logic             vme_wr_q;
  logic             vme_rd_q;
  logic [22:0]      vme_addr_q;
  logic [15:0]      vme_wr_data_q;
  logic [NREQ-1:0]  req_ack_q;
  logic [15:0]      rsp_data_q;
  logic             rsp_err_q;
  logic             busy_q;
  logic [7:0]       tmo_count_q;
  logic             spurious_q;

  // Round-robin pick: scan offsets 1..NREQ from last_grant; the first
  // pending requester wins. Loops unroll to constant indices.
  logic             pick_vld;
  logic [GW-1:0]    pick;
  logic             pick_wr;
  logic [22:0]      pick_addr;
  logic [15:0]      pick_wdata;

  always_comb begin
    pick_vld   = 1'b0;
    pick       = '0;
    pick_wr    = 1'b0;
    pick_addr  = '0;
    pick_wdata = '0;
    for (int off = 1; off <= NREQ; off++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pick_vld && bus.req_vld[i] &&
            (i == (int'(last_grant) + off) % NREQ)) begin
          pick_vld   = 1'b1;
          pick       = GW'(i);
          pick_wr    = bus.req_wr[i];
          pick_addr  = bus.req_addr[i*23 +: 23];
          pick_wdata = bus.req_wdata[i*16 +: 16];
        end
      end
    end
  end

  // Completion is accepted in ISSUE as well as WAIT; it beats a timeout
  // landing in the same cycle.
  logic            cpl_hit;
  logic            tmo_hit;
  logic            spur_hit;
  logic [NREQ-1:0] grant_onehot;

  assign cpl_hit      = bus.vme_cmd_rd && (state == S_ISSUE || state == S_WAIT);
  assign tmo_hit      = (state == S_WAIT) && !bus.vme_cmd_rd && (timer == TMO_LAST);
  assign spur_hit     = bus.vme_cmd_rd && (state == S_IDLE || state == S_DONE);
  assign grant_onehot = NREQ'(1) << grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      grant         <= '0;
      last_grant    <= GW'(NREQ - 1);
      timer         <= '0;
      vme_cmd_q     <= 1'b0;
      vme_wr_q      <= 1'b0;
      vme_rd_q      <= 1'b0;
      vme_addr_q    <= '0;
      vme_wr_data_q <= '0;
      req_ack_q     <= '0;
      rsp_data_q    <= '0;
      rsp_err_q     <= 1'b0;
      busy_q        <= 1'b0;
      tmo_count_q   <= '0;
      spurious_q    <= 1'b0;
    end else begin
      // Pulse outputs default low; responses read 0 outside the ack cycle.
      vme_cmd_q  <= 1'b0;
      req_ack_q  <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;

      if (spur_hit) begin
        spurious_q <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            grant         <= pick;
            vme_addr_q    <= pick_addr;
            vme_wr_data_q <= pick_wdata;
            vme_wr_q      <= pick_wr;
            vme_rd_q      <= ~pick_wr;
            vme_cmd_q     <= 1'b1;
            busy_q        <= 1'b1;
            state         <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          timer <= '0;
          state <= cpl_hit ? S_DONE : S_WAIT;
        end

        S_WAIT: begin
          timer <= timer + 1'b1;
          if (cpl_hit || tmo_hit) begin
            state <= S_DONE;
          end
          if (tmo_hit && tmo_count_q != 8'hFF) begin
            tmo_count_q <= tmo_count_q + 8'd1;
          end
        end

        S_DONE: begin
          last_grant <= grant;
          busy_q     <= 1'b0;
          state      <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase

      // Registering the response here puts req_ack in the DONE cycle.
      if (cpl_hit || tmo_hit) begin
        req_ack_q  <= grant_onehot;
        rsp_err_q  <= tmo_hit;
        rsp_data_q <= (cpl_hit && !vme_wr_q) ? bus.vme_rd_data : 16'h0000;
        vme_wr_q   <= 1'b0;
        vme_rd_q   <= 1'b0;
      end
    end
  end

  assign bus.vme_cmd     = vme_cmd_q;
  assign bus.vme_wr      = vme_wr_q;
  assign bus.vme_rd      = vme_rd_q;
  assign bus.vme_addr    = vme_addr_q;
  assign bus.vme_wr_data = vme_wr_data_q;
  assign bus.req_ack     = req_ack_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.busy        = busy_q;
  assign bus.tmo_count   = tmo_count_q;
  assign bus.spurious    = spurious_q;

endmodule

// File: tb/tb_vme_cmd_arbiter.sv
// tb/tb_vme_cmd_arbiter.sv - directed self-checking bench for vme_cmd_arbiter
module tb_vme_cmd_arbiter;
  localparam int NREQ = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  int   dbl_cmd = 0;
  int   multi_ack = 0;
  int   stray_rsp = 0;
  logic prev_cmd = 1'b0;

  vme_cmd_arbiter_if #(.NREQ(NREQ)) bus ();

  vme_cmd_arbiter #(
    .NREQ   (NREQ),
    .TMO_W  (8),
    .TIMEOUT(200)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.vme_cmd && prev_cmd) dbl_cmd++;
    if ($countones(bus.req_ack) > 1) multi_ack++;
    if (bus.req_ack == '0 && (bus.rsp_data != 16'h0 || bus.rsp_err)) stray_rsp++;
    prev_cmd = bus.vme_cmd;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cmd(input string tag, output int at);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.vme_cmd && n < 50);
    at = cyc;
    check({tag, "_cmd"}, 32'(bus.vme_cmd), 32'd1);
  endtask

  task automatic wait_ack(input string tag, input int bound, output int at);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.req_ack == '0 && n < bound);
    at = cyc;
    check({tag, "_ack_seen"}, 32'(bus.req_ack != '0), 32'd1);
  endtask

  task automatic pulse_cpl(input logic [15:0] d);
    bus.vme_cmd_rd  = 1'b1;
    bus.vme_rd_data = d;
    @(negedge clk);
    bus.vme_cmd_rd  = 1'b0;
    bus.vme_rd_data = 16'h0;
  endtask

  initial begin
    int c0;
    int ca;
    int prev_ack;

    bus.req_vld     = '0;
    bus.req_wr      = '0;
    bus.req_addr    = '0;
    bus.req_wdata   = '0;
    bus.vme_cmd_rd  = 1'b0;
    bus.vme_rd_data = 16'h0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy",     32'(bus.busy),      32'd0);
    check("rst_vme_cmd",  32'(bus.vme_cmd),   32'd0);
    check("rst_req_ack",  32'(bus.req_ack),   32'd0);
    check("rst_tmo",      32'(bus.tmo_count), 32'd0);
    check("rst_spurious", 32'(bus.spurious),  32'd0);
    check("rst_vme_addr", 32'(bus.vme_addr),  32'd0);
    rst = 1'b0;

    // Single read on requester 0, completion 5 cycles after vme_cmd;
    // requester drops req_vld and changes its address early.
    bus.req_addr = {23'h000200, 23'h000010};
    bus.req_wr   = 2'b00;
    bus.req_vld  = 2'b01;
    wait_cmd("rd", c0);
    check("rd_addr",  32'(bus.vme_addr), 32'h10);
    check("rd_rd",    32'(bus.vme_rd),   32'd1);
    check("rd_wr",    32'(bus.vme_wr),   32'd0);
    check("rd_busy",  32'(bus.busy),     32'd1);
    bus.req_vld  = 2'b00;
    bus.req_addr = {23'h000200, 23'h7FFFFF};
    repeat (5) @(negedge clk);
    check("rd_cmd_one_cycle", 32'(bus.vme_cmd),  32'd0);
    check("rd_addr_held",     32'(bus.vme_addr), 32'h10);
    pulse_cpl(16'hBEEF);
    check("rd_ack",     32'(bus.req_ack),  32'h1);
    check("rd_data",    32'(bus.rsp_data), 32'hBEEF);
    check("rd_err",     32'(bus.rsp_err),  32'd0);
    check("rd_latency", 32'(cyc - c0),     32'd6);
    check("rd_strobe_drop", 32'(bus.vme_rd), 32'd0);
    @(negedge clk);
    check("rd_ack_clear",  32'(bus.req_ack),  32'd0);
    check("rd_data_clear", 32'(bus.rsp_data), 32'd0);
    check("rd_idle",       32'(bus.busy),     32'd0);

    // Write on requester 1; read data on the bus must not leak into rsp_data
    bus.req_addr  = {23'h00002A, 23'h000010};
    bus.req_wdata = {16'h1234, 16'h0000};
    bus.req_wr    = 2'b10;
    bus.req_vld   = 2'b10;
    wait_cmd("wr", c0);
    check("wr_addr",  32'(bus.vme_addr),    32'h2A);
    check("wr_wdata", 32'(bus.vme_wr_data), 32'h1234);
    check("wr_wr",    32'(bus.vme_wr),      32'd1);
    check("wr_rd",    32'(bus.vme_rd),      32'd0);
    repeat (2) @(negedge clk);
    pulse_cpl(16'hFFFF);
    check("wr_ack",  32'(bus.req_ack),  32'h2);
    check("wr_data", 32'(bus.rsp_data), 32'h0);
    check("wr_err",  32'(bus.rsp_err),  32'd0);
    bus.req_vld = 2'b00;
    bus.req_wr  = 2'b00;
    @(negedge clk);

    // Contention: both held, expect 0,1,0,1 with one IDLE cycle before each cmd
    bus.req_addr = {23'h000200, 23'h000100};
    bus.req_vld  = 2'b11;
    prev_ack = 0;
    for (int k = 0; k < 4; k++) begin
      wait_cmd($sformatf("rr%0d", k), c0);
      if (k > 0) check($sformatf("rr%0d_gap", k), 32'(c0 - prev_ack), 32'd2);
      check($sformatf("rr%0d_addr", k), 32'(bus.vme_addr), (k % 2 == 0) ? 32'h100 : 32'h200);
      @(negedge clk);
      pulse_cpl(16'h0100 + 16'(k));
      check($sformatf("rr%0d_ack", k),  32'(bus.req_ack),  (k % 2 == 0) ? 32'h1 : 32'h2);
      check($sformatf("rr%0d_data", k), 32'(bus.rsp_data), 32'h100 + 32'(k));
      prev_ack = cyc;
      if (k == 3) bus.req_vld = 2'b00;
    end
    @(negedge clk);

    // Timeout with no completion: ack 200 cycles after entering WAIT
    bus.req_addr = {23'h000200, 23'h000300};
    bus.req_vld  = 2'b01;
    wait_cmd("tmo", c0);
    wait_ack("tmo", 300, ca);
    check("tmo_latency", 32'(ca - c0),       32'd201);
    check("tmo_ack",     32'(bus.req_ack),   32'h1);
    check("tmo_err",     32'(bus.rsp_err),   32'd1);
    check("tmo_data",    32'(bus.rsp_data),  32'h0);
    check("tmo_count1",  32'(bus.tmo_count), 32'd1);
    bus.req_vld = 2'b00;
    @(negedge clk);

    // Completion in the final WAIT cycle beats the timeout
    bus.req_vld = 2'b10;
    wait_cmd("late", c0);
    repeat (200) @(negedge clk);
    check("late_no_early_ack", 32'(bus.req_ack), 32'd0);
    pulse_cpl(16'h5A5A);
    check("late_latency", 32'(cyc - c0),       32'd201);
    check("late_ack",     32'(bus.req_ack),   32'h2);
    check("late_err",     32'(bus.rsp_err),   32'd0);
    check("late_data",    32'(bus.rsp_data),  32'h5A5A);
    check("late_tmo",     32'(bus.tmo_count), 32'd1);
    bus.req_vld = 2'b00;
    @(negedge clk);

    // Completion during ISSUE, then a spurious pulse in IDLE
    bus.req_addr = {23'h000200, 23'h000040};
    bus.req_vld  = 2'b01;
    wait_cmd("iss", c0);
    pulse_cpl(16'hC0DE);
    check("iss_ack",     32'(bus.req_ack),  32'h1);
    check("iss_data",    32'(bus.rsp_data), 32'hC0DE);
    check("iss_latency", 32'(cyc - c0),     32'd1);
    bus.req_vld = 2'b00;
    @(negedge clk);
    check("spur_before", 32'(bus.spurious), 32'd0);
    pulse_cpl(16'h1111);
    check("spur_set",  32'(bus.spurious), 32'd1);
    check("spur_ack",  32'(bus.req_ack),  32'd0);
    check("spur_busy", 32'(bus.busy),     32'd0);
    @(negedge clk);

    // Reset mid-WAIT on requester 1; afterwards requester 0 must win
    bus.req_vld = 2'b10;
    wait_cmd("mrst", c0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_busy",     32'(bus.busy),      32'd0);
    check("mrst_ack",      32'(bus.req_ack),   32'd0);
    check("mrst_rd",       32'(bus.vme_rd),    32'd0);
    check("mrst_spurious", 32'(bus.spurious),  32'd0);
    check("mrst_tmo",      32'(bus.tmo_count), 32'd0);
    bus.req_vld = 2'b11;
    wait_cmd("post", c0);
    check("post_addr", 32'(bus.vme_addr), 32'h40);
    bus.req_vld = 2'b00;
    @(negedge clk);
    pulse_cpl(16'h7777);
    check("post_ack",  32'(bus.req_ack),  32'h1);
    check("post_data", 32'(bus.rsp_data), 32'h7777);
    repeat (2) @(negedge clk);

    check("no_double_cmd", 32'(dbl_cmd),   32'd0);
    check("one_hot_ack",   32'(multi_ack), 32'd0);
    check("rsp_zero_idle", 32'(stray_rsp), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vme_cmd_arbiter.md
Name: vme_cmd_arbiter

Overview:
- Shares the single-transaction command port of vme_master among NREQ requesters, e.g. test_controller and a register-scan engine.
- Round-robin arbitration; the winning request is latched and issued as a one-cycle vme_cmd pulse.
- Waits for the vme_cmd_rd completion pulse, or for a timeout, then returns read data or error status to the granted requester.
- Sits between the requesters and vme_master in the simulation/test-controller layer.

Parameters:
NREQ, 2, number of requesters (2..4)
TMO_W, 8, timeout counter width
TIMEOUT, 200, WAIT-state cycles before abort (1..2^TMO_W-1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
req_vld  in  NREQ  request pending; held high until matching req_ack
req_wr  in  NREQ  1=write, 0=read, per requester
req_addr  in  NREQ*23  VME address [23:1], requester i at bits [23i+22:23i]
req_wdata  in  NREQ*16  write data, requester i at bits [16i+15:16i]
req_ack  out  NREQ  one-cycle completion pulse to the granted requester
rsp_data  out  16  read data; valid only while req_ack is non-zero
rsp_err  out  1  timeout flag; valid only while req_ack is non-zero
vme_cmd  out  1  one-cycle start pulse to vme_master
vme_wr  out  1  write strobe level to vme_master
vme_rd  out  1  read strobe level to vme_master
vme_addr  out  23  latched address
vme_wr_data  out  16  latched write data
vme_cmd_rd  in  1  completion pulse from vme_master
vme_rd_data  in  16  read data; valid with vme_cmd_rd
busy  out  1  high in any state other than IDLE
tmo_count  out  8  saturating count of timeouts
spurious  out  1  sticky: vme_cmd_rd seen in IDLE or DONE

Behaviour:
- Reset values:
  - state = IDLE; all outputs 0.
  - last_grant = NREQ-1, so requester 0 wins first after reset.
  - Timer, tmo_count and spurious are cleared.
- Reset during ISSUE, WAIT or DONE abandons the transaction. No ack is issued; the requester must re-request.
- State machine: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE, when any req_vld bit is set:
  - Grant goes to the first set bit searching upward from last_grant+1, modulo NREQ.
  - Latch grant, vme_addr, vme_wr_data and wr into registers; go to ISSUE.
  - No req_vld bit set: stay in IDLE.
- ISSUE (exactly one cycle):
  - vme_cmd = 1.
  - vme_wr = wr and vme_rd = ~wr; both are held through WAIT.
  - Timer cleared.
  - If vme_cmd_rd = 1 in this cycle, treat it as completion and go directly to DONE; otherwise go to WAIT.
- WAIT, the timer increments every cycle:
  - vme_cmd_rd = 1: capture vme_rd_data (reads) or 0 (writes), set err = 0, go to DONE.
  - Otherwise, when the timer equals TIMEOUT-1: err = 1, data = 0, tmo_count += 1 (saturating at 255), go to DONE.
  - If completion arrives in the same cycle as the timeout, completion wins and err = 0.
- DONE (one cycle):
  - req_ack[grant] = 1, with rsp_data and rsp_err driven.
  - vme_wr and vme_rd drop to 0.
  - last_grant = grant; go to IDLE.
  - rsp_data and rsp_err read 0 whenever req_ack = 0.
- Minimum latency for a request seen in IDLE at cycle k:
  - vme_cmd at k+1.
  - If completion comes at cycle c, ack at c+1.
  - Back-to-back transactions have at least 1 IDLE cycle between ack and the next vme_cmd.
- Latched fields are fixed from ISSUE through DONE; changes on the req_* inputs are ignored.
- A requester that drops req_vld early is still acked.
- vme_cmd_rd seen in IDLE or DONE sets spurious (cleared only by rst) and is otherwise ignored.
- vme_cmd never asserts in two consecutive cycles.
- At most one req_ack bit is set at any time.

Test Plan:
- Single read: req_vld=01, req_wr=0, addr 0x000010 on requester 0; master returns vme_cmd_rd with 0xBEEF 5 cycles after vme_cmd -> vme_cmd pulse of 1 cycle with vme_addr=0x000010, vme_rd=1; req_ack=01 with rsp_data=0xBEEF and rsp_err=0.
- Write: requester 1 writes 0x1234 to 0x00002A -> vme_wr=1, vme_wr_data=0x1234; req_ack=10 with rsp_data=0.
- Contention: req_vld=11 held, 4 transactions -> grant order 0,1,0,1; each vme_cmd separated by ≥1 IDLE cycle.
- Timeout: TIMEOUT=200 with no completion -> ack exactly 200 cycles after entering WAIT; rsp_err=1, tmo_count=1. A completion arriving in that final cycle instead -> rsp_err=0.
- Boundary pulses: vme_cmd_rd during ISSUE -> ack in the next cycle with that data. vme_cmd_rd in IDLE -> spurious=1 and no ack.
- Reset mid-WAIT: rst=1 for 1 cycle -> no ack, busy=0; next request goes to requester 0 even if requester 1 was previously granted.
